link_burst: RTL

LINK_BURST -- requirements
Module: link_burst

---
 rtl/link_burst.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/link_burst.sv
// Burst transfer over an internal req/ack link: a master FSM issues
// base+k words, a slave FSM captures them and keeps a count and checksum.
module link_burst #(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MAX_BURST = 16,
    parameter  int unsigned ACK_DELAY = 2,
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] base,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              req,
    output logic              ack,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rx_count,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned        DLY_W    = 4;
    localparam logic [DLY_W-1:0]   ACK_LAST = DLY_W'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0]   LEN_MAX  = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT_ACK,
        M_WAIT_REL,
        M_DONE
    } mst_state_e;

    typedef enum logic {
        S_IDLE,
        S_RELEASE
    } slv_state_e;

    // Master state
    mst_state_e        mst_state_q, mst_state_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Slave state
    slv_state_e        slv_state_q, slv_state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              ack_q, ack_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    logic              accept_c;
    logic              word_end_c;
    logic              finish_c;
    logic              hit_c;
    logic [CNT_W-1:0]  len_clip_c;
    logic              len_nz_c;

    assign len_clip_c = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
    assign len_nz_c   = (len_clip_c != '0);

    // Slave sees a pending word: level mismatch in 2-phase, req-without-ack in 4-phase
    assign hit_c = mode_q ? (req_q != ack_q) : (req_q && !ack_q);

    // Master next-state and outputs
    always_comb begin
        mst_state_d = mst_state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        idx_d       = idx_q;
        req_d       = req_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        accept_c    = 1'b0;
        word_end_c  = 1'b0;
        finish_c    = 1'b0;

        case (mst_state_q)
            M_IDLE: begin
                if (start) begin
                    accept_c    = 1'b1;
                    mode_d      = mode;
                    len_d       = len_clip_c;
                    idx_d       = '0;
                    mst_state_d = M_WAIT_ACK;
                    busy_d      = len_nz_c;
                    if (len_nz_c) begin
                        data_d = base;
                        req_d  = mode ? ~req_q : 1'b1;
                    end else begin
                        req_d  = mode ? req_q : 1'b0;
                    end
                end
            end
            M_WAIT_ACK: begin
                if (len_q == '0) begin
                    finish_c = 1'b1;
                end else if (mode_q) begin
                    if (ack_q == req_q) begin
                        word_end_c = 1'b1;
                    end
                end else if (ack_q) begin
                    req_d       = 1'b0;
                    mst_state_d = M_WAIT_REL;
                end
            end
            M_WAIT_REL: begin
                if (!ack_q) begin
                    word_end_c = 1'b1;
                end
            end
            M_DONE: begin
                mst_state_d = M_IDLE;
            end
            default: begin
                mst_state_d = M_IDLE;
            end
        endcase

        // A completed handshake either launches the next word or ends the burst
        if (word_end_c) begin
            if (idx_q == CNT_W'(len_q - 1'b1)) begin
                finish_c = 1'b1;
            end else begin
                idx_d       = CNT_W'(idx_q + 1'b1);
                data_d      = DATA_W'(data_q + 1'b1);
                req_d       = mode_q ? ~req_q : 1'b1;
                mst_state_d = M_WAIT_ACK;
            end
        end

        if (finish_c) begin
            mst_state_d = M_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
        end
    end

    // Slave next-state and outputs
    always_comb begin
        slv_state_d = slv_state_q;
        dly_d       = dly_q;
        ack_d       = ack_q;
        rx_count_d  = rx_count_q;
        checksum_d  = checksum_q;

        if (accept_c) begin
            // A 4-phase burst must start from ack=0 even after a 2-phase burst left it high
            slv_state_d = S_IDLE;
            dly_d       = '0;
            rx_count_d  = '0;
            checksum_d  = '0;
            if (!mode) begin
                ack_d = 1'b0;
            end
        end else begin
            case (slv_state_q)
                S_IDLE: begin
                    if (hit_c) begin
                        if (dly_q == ACK_LAST) begin
                            dly_d      = '0;
                            ack_d      = ~ack_q;
                            rx_count_d = CNT_W'(rx_count_q + 1'b1);
                            checksum_d = DATA_W'(checksum_q + data_q);
                            if (!mode_q) begin
                                slv_state_d = S_RELEASE;
                            end
                        end else begin
                            dly_d = DLY_W'(dly_q + 1'b1);
                        end
                    end else begin
                        dly_d = '0;
                    end
                end
                S_RELEASE: begin
                    if (!req_q) begin
                        ack_d       = 1'b0;
                        slv_state_d = S_IDLE;
                    end
                end
                default: begin
                    slv_state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mst_state_q <= M_IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            req_q       <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slv_state_q <= S_IDLE;
            dly_q       <= '0;
            ack_q       <= 1'b0;
            rx_count_q  <= '0;
            checksum_q  <= '0;
        end else begin
            mst_state_q <= mst_state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            slv_state_q <= slv_state_d;
            dly_q       <= dly_d;
            ack_q       <= ack_d;
            rx_count_q  <= rx_count_d;
            checksum_q  <= checksum_d;
        end
    end

    assign req      = req_q;
    assign ack      = ack_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_count = rx_count_q;
    assign checksum = checksum_q;

endmodule
